oven_sequencer: RTL and testbench
=================================

OVEN_SEQUENCER -- requirements
Module: oven_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second tick; legal range >=2.
REQ-002 Parameter MAX_TIME, default 20, maximum cook time in seconds; legal range 1..31.
REQ-003 Parameter ALARM_SECS, default 5, alarm duration in ticks; legal range 1..15.
REQ-004 clk  in  1  system clock, 100 MHz, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 start  in  1  debounced one-cycle pulse: start, pause/resume, alarm acknowledge.
REQ-007 cancel  in  1  debounced one-cycle pulse: abort cook, pause or alarm.
REQ-008 adjust_req  in  1  level; clock-adjust mode requested.
REQ-009 sel_time  in  5  requested cook seconds, sampled on start in IDLE.
REQ-010 remaining  out  5  seconds left in the cook countdown.
REQ-011 heater_on  out  1  high only in COOK.
REQ-012 alarm  out  1  high only in ALARM.
REQ-013 done  out  1  one-cycle pulse on the COOK->ALARM transition.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 disp_sel  out  2  display owner: 00 clock, 01 adjust, 10 cook/pause/alarm; 11 never driven.
REQ-016 sec_tick  out  1  one-cycle pulse from the internal prescaler.

Function
REQ-017 States SHALL be IDLE, ADJUST, COOK, PAUSE, ALARM; heater_on, alarm, busy and disp_sel are Moore-decoded from the state register.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and pulse sec_tick in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-019 The prescaler SHALL be cleared on entry to COOK from IDLE, frozen in PAUSE, and free-running in all other states.
REQ-020 The first decrement after a start SHALL occur TICK_DIV cycles after the start edge.
REQ-021 IDLE with adjust_req=1 SHALL move to ADJUST; adjust_req has priority over start.
REQ-022 ADJUST SHALL return to IDLE when adjust_req=0; start and cancel are ignored in ADJUST.
REQ-023 IDLE + start with sel_time=0 SHALL be ignored and the block stays in IDLE.
REQ-024 IDLE + start with sel_time in 1..MAX_TIME SHALL load remaining=sel_time and move to COOK.
REQ-025 IDLE + start with sel_time>MAX_TIME SHALL clamp the load to MAX_TIME.
REQ-026 In COOK each sec_tick SHALL decrement remaining by 1; the decrement from 1 to 0 SHALL move to ALARM and pulse done.
REQ-027 COOK + start SHALL move to PAUSE with remaining held.
REQ-028 PAUSE + start SHALL return to COOK with the prescaler resuming from its frozen value.
REQ-029 cancel in COOK or PAUSE SHALL go to IDLE with remaining=0 and no done pulse.
REQ-030 cancel SHALL win over a simultaneous start or sec_tick.
REQ-031 adjust_req SHALL be ignored in COOK, PAUSE and ALARM.
REQ-032 ALARM SHALL count sec_ticks and return to IDLE after ALARM_SECS ticks.
REQ-033 start or cancel in ALARM SHALL return to IDLE on the next edge.
REQ-034 remaining SHALL never underflow below 0 or exceed MAX_TIME.

Reset
REQ-035 reset SHALL force state IDLE, prescaler 0 and alarm counter 0, with all outputs at 0 (disp_sel=00), immediately and without waiting for clk.
REQ-036 reset asserted mid-COOK or mid-ALARM SHALL abort with no done pulse; after release the block waits for a new start.

Verification (TICK_DIV=4, MAX_TIME=20, ALARM_SECS=5)
REQ-037 start with sel_time=3 -> COOK, remaining 3,2,1,0 at 4-cycle spacing; done pulses once; ALARM for 20 cycles; then IDLE.
REQ-038 sel_time=25 + start -> remaining=20; sel_time=0 + start -> stays IDLE, busy=0.
REQ-039 start at remaining=5 -> PAUSE, remaining held 5 for 30 cycles, heater_on=0; start -> COOK, next decrement after the remaining prescaler count.
REQ-040 cancel coincident with sec_tick at remaining=1 -> IDLE, remaining=0, done never pulses.
REQ-041 adjust_req=1 plus start in IDLE -> ADJUST, disp_sel=01; adjust_req asserted during COOK -> ignored, disp_sel=10.
REQ-042 reset asserted between edges mid-COOK -> outputs 0 asynchronously; start after release resumes normal operation.

Source files
------------

// File: rtl/oven_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : oven_sequencer_if
// Brief    : Control/status bundle between the oven front panel and sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface oven_sequencer_if;
    logic       start;
    logic       cancel;
    logic       adjust_req;
    logic [4:0] sel_time;
    logic [4:0] remaining;
    logic       heater_on;
    logic       alarm;
    logic       done;
    logic       busy;
    logic [1:0] disp_sel;
    logic       sec_tick;

    modport master (
        output start, cancel, adjust_req, sel_time,
        input  remaining, heater_on, alarm, done, busy, disp_sel, sec_tick
    );

    modport slave (
        input  start, cancel, adjust_req, sel_time,
        output remaining, heater_on, alarm, done, busy, disp_sel, sec_tick
    );
endinterface
`default_nettype wire

// File: rtl/oven_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : oven_sequencer
// Brief    : Microwave cook sequencer: countdown, pause, alarm, clock adjust.
// Revision : 1.0  initial release
// ============================================================================
module oven_sequencer #(
    parameter int TICK_DIV   = 100000000,
    parameter int MAX_TIME   = 20,
    parameter int ALARM_SECS = 5
) (
    input  logic             clk,
    input  logic             reset,
    oven_sequencer_if.slave  bus
);

    localparam int                 c_PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST   = c_PRE_W'(TICK_DIV - 1);
    localparam logic [4:0]         c_MAX_TIME   = 5'(MAX_TIME);
    localparam logic [3:0]         c_ALARM_LAST = 4'(ALARM_SECS - 1);

    typedef enum logic [2:0] {
        c_IDLE   = 3'd0,
        c_ADJUST = 3'd1,
        c_COOK   = 3'd2,
        c_PAUSE  = 3'd3,
        c_ALARM  = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_PRE_W-1:0] r_preCnt;
    logic [4:0]         r_remaining;
    logic [3:0]         r_alarmCnt;
    logic               r_done;

    logic               w_tick;
    logic [4:0]         w_load;
    logic [1:0]         w_dispSel;

    // A frozen count may sit on its last value in PAUSE; the tick is masked there.
    assign w_tick = (r_preCnt == c_PRE_LAST) && (r_state != c_PAUSE);
    assign w_load = (bus.sel_time > c_MAX_TIME) ? c_MAX_TIME : bus.sel_time;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_preCnt    <= '0;
            r_remaining <= '0;
            r_alarmCnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != c_PAUSE) begin
                r_preCnt <= w_tick ? '0 : r_preCnt + c_PRE_W'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.adjust_req) begin
                        r_state <= c_ADJUST;
                    end else if (bus.start && (bus.sel_time != 5'd0)) begin
                        r_state     <= c_COOK;
                        r_remaining <= w_load;
                        r_preCnt    <= '0;
                    end
                end

                c_ADJUST: begin
                    if (!bus.adjust_req) begin
                        r_state <= c_IDLE;
                    end
                end

                c_COOK: begin
                    if (bus.cancel) begin
                        r_state     <= c_IDLE;
                        r_remaining <= '0;
                    end else if (bus.start) begin
                        r_state <= c_PAUSE;
                    end else if (w_tick) begin
                        if (r_remaining <= 5'd1) begin
                            r_remaining <= '0;
                            r_state     <= c_ALARM;
                            r_alarmCnt  <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - 5'd1;
                        end
                    end
                end

                c_PAUSE: begin
                    if (bus.cancel) begin
                        r_state     <= c_IDLE;
                        r_remaining <= '0;
                    end else if (bus.start) begin
                        r_state <= c_COOK;
                    end
                end

                c_ALARM: begin
                    if (bus.start || bus.cancel) begin
                        r_state    <= c_IDLE;
                        r_alarmCnt <= '0;
                    end else if (w_tick) begin
                        if (r_alarmCnt == c_ALARM_LAST) begin
                            r_state    <= c_IDLE;
                            r_alarmCnt <= '0;
                        end else begin
                            r_alarmCnt <= r_alarmCnt + 4'd1;
                        end
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dispSel = 2'b00;
        case (r_state)
            c_ADJUST:                  w_dispSel = 2'b01;
            c_COOK, c_PAUSE, c_ALARM:  w_dispSel = 2'b10;
            default:                   w_dispSel = 2'b00;
        endcase
    end

    assign bus.remaining = r_remaining;
    assign bus.heater_on = (r_state == c_COOK);
    assign bus.alarm     = (r_state == c_ALARM);
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.disp_sel  = w_dispSel;
    assign bus.sec_tick  = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_oven_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oven_sequencer
// Brief    : Scoreboard bench for oven_sequencer with a behavioural oven model.
// Revision : 1.0  initial release
// ============================================================================
module tb_oven_sequencer;

    localparam int TD = 4;
    localparam int MT = 20;
    localparam int AS = 5;

    localparam int MD_IDLE   = 0;
    localparam int MD_ADJUST = 1;
    localparam int MD_COOK   = 2;
    localparam int MD_PAUSE  = 3;
    localparam int MD_ALARM  = 4;

    typedef struct packed {
        logic [4:0] rem;
        logic       heat;
        logic       alm;
        logic       dn;
        logic       bsy;
        logic [1:0] disp;
        logic       tick;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    oven_sequencer_if bus();

    oven_sequencer #(
        .TICK_DIV   (TD),
        .MAX_TIME   (MT),
        .ALARM_SECS (AS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    armed  = 1'b0;
    snap_t expQ[$];

    // Oven model: mode, seconds left, prescaler phase, alarm cycles left.
    int mMode      = MD_IDLE;
    int mRem       = 0;
    int mPhase     = 0;
    int mAlarmLeft = 0;
    bit mDone      = 1'b0;

    function automatic snap_t modelSnap();
        snap_t s;
        s.rem  = 5'(mRem);
        s.heat = (mMode == MD_COOK);
        s.alm  = (mMode == MD_ALARM);
        s.dn   = mDone;
        s.bsy  = (mMode != MD_IDLE);
        s.disp = (mMode == MD_IDLE) ? 2'b00 : (mMode == MD_ADJUST) ? 2'b01 : 2'b10;
        s.tick = (mPhase == TD - 1) && (mMode != MD_PAUSE);
        return s;
    endfunction

    function automatic snap_t dutSnap();
        snap_t s;
        s.rem  = bus.remaining;
        s.heat = bus.heater_on;
        s.alm  = bus.alarm;
        s.dn   = bus.done;
        s.bsy  = bus.busy;
        s.disp = bus.disp_sel;
        s.tick = bus.sec_tick;
        return s;
    endfunction

    task automatic modelAdvance(input bit s, input bit c, input bit a, input logic [4:0] sel);
        bit tick;
        int nextPhase;
        tick      = (mPhase == TD - 1) && (mMode != MD_PAUSE);
        nextPhase = (mMode == MD_PAUSE) ? mPhase : (mPhase + 1) % TD;
        mDone     = 1'b0;
        case (mMode)
            MD_IDLE: begin
                if (a) mMode = MD_ADJUST;
                else if (s && sel != 5'd0) begin
                    mMode     = MD_COOK;
                    mRem      = (int'(sel) > MT) ? MT : int'(sel);
                    nextPhase = 0;
                end
            end
            MD_ADJUST: if (!a) mMode = MD_IDLE;
            MD_COOK: begin
                if (c) begin
                    mMode = MD_IDLE;
                    mRem  = 0;
                end else if (s) mMode = MD_PAUSE;
                else if (tick) begin
                    mRem = mRem - 1;
                    if (mRem == 0) begin
                        mMode      = MD_ALARM;
                        mAlarmLeft = AS * TD;
                        mDone      = 1'b1;
                    end
                end
            end
            MD_PAUSE: begin
                if (c) begin
                    mMode = MD_IDLE;
                    mRem  = 0;
                end else if (s) mMode = MD_COOK;
            end
            MD_ALARM: begin
                if (s || c) mMode = MD_IDLE;
                else begin
                    mAlarmLeft = mAlarmLeft - 1;
                    if (mAlarmLeft == 0) mMode = MD_IDLE;
                end
            end
            default: mMode = MD_IDLE;
        endcase
        mPhase = nextPhase;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit s, input bit c, input bit a, input logic [4:0] sel);
        bus.start      = s;
        bus.cancel     = c;
        bus.adjust_req = a;
        bus.sel_time   = sel;
        modelAdvance(s, c, a, sel);
        expQ.push_back(modelSnap());
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        snap_t act;
        act = dutSnap();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s t=%0t got rem=%0d heat=%b alarm=%b done=%b busy=%b disp=%b tick=%b, expected all zero",
                     name, $time, act.rem, act.heat, act.alm, act.dn, act.bsy, act.disp, act.tick);
        end
    endtask

    // Reset pulse asserted between clock edges; outputs must clear before any edge.
    task automatic asyncReset();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        #2 reset = 1'b1;
        #1 checkAllZero("async_reset");
        mMode  = MD_IDLE;
        mRem   = 0;
        mPhase = 0;
        mDone  = 1'b0;
        expQ.push_back(modelSnap());
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        snap_t exp;
        snap_t act;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t got no expected entry, required one", $time);
                end else begin
                    exp = expQ.pop_front();
                    act = dutSnap();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL outputs t=%0t got rem=%0d heat=%b alarm=%b done=%b busy=%b disp=%b tick=%b expected rem=%0d heat=%b alarm=%b done=%b busy=%b disp=%b tick=%b",
                                 $time, act.rem, act.heat, act.alm, act.dn, act.bsy, act.disp, act.tick,
                                 exp.rem, exp.heat, exp.alm, exp.dn, exp.bsy, exp.disp, exp.tick);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog t=%0t got no finish, required end of stimulus", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit adj;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.adjust_req = 1'b0;
        bus.sel_time   = 5'd0;
        #3 checkAllZero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        armed = 1'b1;

        // Basic cook of 3 s through alarm timeout.
        step(1, 0, 0, 5'd3);
        repeat (40) step(0, 0, 0, 5'd0);

        // Clamp above MAX_TIME, then zero-time start ignored.
        step(1, 0, 0, 5'd25);
        repeat (3) step(0, 0, 0, 5'd0);
        step(0, 1, 0, 5'd0);
        step(1, 0, 0, 5'd0);
        repeat (3) step(0, 0, 0, 5'd0);

        // Pause at 5 s, hold 30 cycles, resume to completion.
        step(1, 0, 0, 5'd9);
        for (int k = 0; k < 200 && mRem != 5; k++) step(0, 0, 0, 5'd0);
        repeat (2) step(0, 0, 0, 5'd0);
        step(1, 0, 0, 5'd0);
        repeat (30) step(0, 0, 0, 5'd0);
        step(1, 0, 0, 5'd0);
        for (int k = 0; k < 200 && mMode != MD_IDLE; k++) step(0, 0, 0, 5'd0);

        // Cancel on the same edge as the final tick.
        step(1, 0, 0, 5'd2);
        for (int k = 0; k < 100 && !(mRem == 1 && mPhase == TD - 1); k++) step(0, 0, 0, 5'd0);
        step(0, 1, 0, 5'd0);
        repeat (5) step(0, 0, 0, 5'd0);

        // Adjust beats start in IDLE; adjust ignored during cook.
        step(1, 0, 1, 5'd5);
        repeat (5) step(0, 0, 1, 5'd0);
        step(1, 1, 1, 5'd5);
        step(0, 0, 0, 5'd0);
        step(1, 0, 0, 5'd5);
        repeat (6) step(0, 0, 1, 5'd0);
        step(0, 1, 1, 5'd0);
        repeat (3) step(0, 0, 0, 5'd0);

        // Asynchronous reset mid-cook, then a fresh cook.
        step(1, 0, 0, 5'd6);
        repeat (7) step(0, 0, 0, 5'd0);
        asyncReset();
        repeat (2) step(0, 0, 0, 5'd0);
        step(1, 0, 0, 5'd2);
        repeat (20) step(0, 0, 0, 5'd0);
        asyncReset();
        repeat (2) step(0, 0, 0, 5'd0);

        // Randomized traffic.
        adj = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 39) == 0) adj = !adj;
            if ($urandom_range(0, 499) == 0) asyncReset();
            else step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, adj,
                      5'($urandom_range(0, 31)));
        end

        armed = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
